// File: rtl/char_scan_ctrl_pkg.sv
// Shared constants, loader state encoding and the column one-hot helper for char_scan_ctrl.
package char_scan_pkg;

    localparam int         NUM_COLS    = 5;
    localparam int         NUM_ROWS    = 7;
    localparam logic [3:0] FINISH_IDX  = 4'd5;
    localparam logic [3:0] CNT_TIMEOUT = 4'hF;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        COMMIT = 2'd2
    } state_e;

    function automatic logic [NUM_COLS-1:0] col_onehot(input logic [2:0] col);
        col_onehot = '0;
        if (col < 3'(NUM_COLS)) col_onehot[col] = 1'b1;
    endfunction

endpackage

// File: rtl/char_scan_ctrl_if.sv
// Character handshake, gen_char fetch port and LED matrix drive bundled for char_scan_ctrl.
interface char_scan_if
    import char_scan_pkg::*;
;
    logic [3:0]          char_code_in;
    logic                char_valid;
    logic                char_ready;
    logic [3:0]          caracter_code;
    logic [3:0]          counter;
    logic [NUM_ROWS-1:0] next_col;
    logic                finish;
    logic [NUM_COLS-1:0] col_sel;
    logic [NUM_ROWS-1:0] row_data;

    modport master (
        input  char_code_in, char_valid, next_col, finish,
        output char_ready, caracter_code, counter, col_sel, row_data
    );

    modport slave (
        output char_code_in, char_valid, next_col, finish,
        input  char_ready, caracter_code, counter, col_sel, row_data
    );

endinterface

// File: rtl/char_scan_ctrl_col_scan_timer.sv
// Free-running column scan timer: slot counter, column index, frame-wrap and blanking flags.
// Blanking flag is only active when CHAR_SCAN_DEADTIME_EN is defined.
module col_scan_timer
    import char_scan_pkg::*;
#(
    parameter int COL_CYCLES = 1000,
    parameter int DEADTIME   = 8
) (
    input  logic       clk,
    input  logic       reset_n,
    output logic [2:0] col_o,
    output logic [2:0] col_d_o,
    output logic       last_cyc_o,
    output logic       frame_wrap_o,
    output logic       dead_d_o
);

    localparam int SW = $clog2(COL_CYCLES);

`ifdef CHAR_SCAN_DEADTIME_EN
    localparam bit DT_EN = 1'b1;
`else
    localparam bit DT_EN = 1'b0;
`endif

    logic [SW-1:0] slot_q, slot_d;
    logic [2:0]    col_q, col_d;
    logic          last_cyc;

    always_comb begin
        last_cyc = (slot_q == SW'(COL_CYCLES - 1));
        slot_d   = last_cyc ? '0 : slot_q + 1'b1;
        col_d    = col_q;
        if (last_cyc) begin
            col_d = (col_q == 3'(NUM_COLS - 1)) ? 3'd0 : col_q + 3'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            slot_q <= '0;
            col_q  <= 3'd0;
        end else begin
            slot_q <= slot_d;
            col_q  <= col_d;
        end
    end

    // Blanking is judged on the next slot value so the registered drive lines up with the slot.
    assign dead_d_o     = DT_EN && (32'(slot_d) < 32'(DEADTIME));
    assign col_o        = col_q;
    assign col_d_o      = col_d;
    assign last_cyc_o   = last_cyc;
    assign frame_wrap_o = last_cyc && (col_q == 3'(NUM_COLS - 1));

endmodule

// File: rtl/char_scan_ctrl.sv
// char_scan_ctrl: fetches a character's five column patterns from gen_char and multiplexes them onto a 5x7 LED matrix.
// Optional anti-ghosting blank at the start of each column slot: define CHAR_SCAN_DEADTIME_EN.
module char_scan_ctrl
    import char_scan_pkg::*;
#(
    parameter int COL_CYCLES  = 1000,
    parameter int HOLD_FRAMES = 50,
    parameter int DEADTIME    = 8
) (
    input  logic        clk,
    input  logic        reset_n,
    char_scan_if.master bus
);

    localparam int            FW       = $clog2(HOLD_FRAMES + 1);
    localparam logic [FW-1:0] HOLD     = FW'(HOLD_FRAMES);
    localparam logic [1:0]    S_IDLE   = 2'(IDLE);
    localparam logic [1:0]    S_LOAD   = 2'(LOAD);
    localparam logic [1:0]    S_COMMIT = 2'(COMMIT);

    logic [1:0]          state_q, state_d;
    logic [3:0]          code_q, code_d;
    logic [3:0]          cnt_q, cnt_d;
    logic                ready_q, ready_d;
    logic [FW-1:0]       frames_q, frames_d;
    logic [NUM_ROWS-1:0] shadow_q [NUM_COLS];
    logic [NUM_ROWS-1:0] shadow_d [NUM_COLS];
    logic [NUM_ROWS-1:0] disp_q   [NUM_COLS];
    logic [NUM_ROWS-1:0] disp_d   [NUM_COLS];
    logic [NUM_COLS-1:0] col_sel_q, col_sel_d;
    logic [NUM_ROWS-1:0] row_q, row_d;

    logic [2:0] col, col_nxt;
    logic       last_cyc, frame_wrap, dead_d, frame_bound;

    col_scan_timer #(
        .COL_CYCLES (COL_CYCLES),
        .DEADTIME   (DEADTIME)
    ) u_timer (
        .clk          (clk),
        .reset_n      (reset_n),
        .col_o        (col),
        .col_d_o      (col_nxt),
        .last_cyc_o   (last_cyc),
        .frame_wrap_o (frame_wrap),
        .dead_d_o     (dead_d)
    );

    assign frame_bound = last_cyc && (col == 3'(NUM_COLS - 1));

    always_comb begin
        state_d  = state_q;
        code_d   = code_q;
        cnt_d    = cnt_q;
        shadow_d = shadow_q;
        disp_d   = disp_q;
        frames_d = frames_q;

        if (frame_wrap && (frames_q < HOLD)) frames_d = frames_q + 1'b1;

        case (state_q)
            S_IDLE: begin
                if (bus.char_valid && ready_q) begin
                    code_d  = bus.char_code_in;
                    cnt_d   = 4'd0;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                if (cnt_q < FINISH_IDX) shadow_d[cnt_q[2:0]] = bus.next_col;
                // Counter freezes on exit so the timeout value cannot wrap back to 0.
                if (bus.finish || (cnt_q == CNT_TIMEOUT)) state_d = S_COMMIT;
                else                                      cnt_d   = cnt_q + 4'd1;
            end
            S_COMMIT: begin
                // Commit overrides a same-edge frame increment, restarting the hold count.
                if (frame_bound) begin
                    disp_d   = shadow_q;
                    frames_d = '0;
                    cnt_d    = 4'd0;
                    state_d  = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        ready_d   = (state_d == S_IDLE) && (frames_d >= HOLD);
        col_sel_d = dead_d ? '0 : col_onehot(col_nxt);
        row_d     = dead_d ? '0 : disp_d[col_nxt];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            code_q    <= 4'd0;
            cnt_q     <= 4'd0;
            ready_q   <= 1'b0;
            frames_q  <= HOLD;
            col_sel_q <= NUM_COLS'(1);
            row_q     <= '0;
            for (int i = 0; i < NUM_COLS; i++) begin
                shadow_q[i] <= '0;
                disp_q[i]   <= '0;
            end
        end else begin
            state_q   <= state_d;
            code_q    <= code_d;
            cnt_q     <= cnt_d;
            ready_q   <= ready_d;
            frames_q  <= frames_d;
            col_sel_q <= col_sel_d;
            row_q     <= row_d;
            shadow_q  <= shadow_d;
            disp_q    <= disp_d;
        end
    end

    assign bus.char_ready    = ready_q;
    assign bus.caracter_code = code_q;
    assign bus.counter       = cnt_q;
    assign bus.col_sel       = col_sel_q;
    assign bus.row_data      = row_q;

endmodule

// File: tb/tb_char_scan_ctrl.sv
// Directed bench for char_scan_ctrl with a behavioural gen_char: next_col = {caracter_code[2:0], counter}.
module tb_char_scan_ctrl;

    localparam int COL_CYCLES  = 10;
    localparam int HOLD_FRAMES = 2;
    localparam int DEADTIME    = 3;
`ifdef CHAR_SCAN_DEADTIME_EN
    localparam int DT_CYC = DEADTIME;
`else
    localparam int DT_CYC = 0;
`endif

    logic       clk       = 1'b0;
    logic       reset_n   = 1'b1;
    logic       valid     = 1'b0;
    logic [3:0] code      = 4'd0;
    logic       no_finish = 1'b0;
    int         n_vec     = 0;
    int         n_bad     = 0;

    always #5 clk = ~clk;

    char_scan_if bus ();

    assign bus.char_valid   = valid;
    assign bus.char_code_in = code;
    assign bus.next_col     = {bus.caracter_code[2:0], bus.counter};
    assign bus.finish       = no_finish ? 1'b0 : (bus.counter == 4'd5);

    char_scan_ctrl #(
        .COL_CYCLES  (COL_CYCLES),
        .HOLD_FRAMES (HOLD_FRAMES),
        .DEADTIME    (DEADTIME)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic handshake(input logic [3:0] c, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (bus.char_ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        if (ok) begin
            valid = 1'b1;
            code  = c;
            tick();
            valid = 1'b0;
        end
    endtask

    task automatic wait_commit(input logic [6:0] first, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (bus.col_sel === 5'b00001 && bus.row_data === first) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic test_reset_init();
        #2 reset_n = 1'b0;
        #1;
        n_vec++; if (bus.char_ready !== 1'b0) begin n_bad++; $display("FAIL por_ready: got %b expected 0", bus.char_ready); end
        n_vec++; if (bus.caracter_code !== 4'd0) begin n_bad++; $display("FAIL por_code: got %h expected 0", bus.caracter_code); end
        n_vec++; if (bus.counter !== 4'd0) begin n_bad++; $display("FAIL por_counter: got %h expected 0", bus.counter); end
        n_vec++; if (bus.col_sel !== 5'b00001) begin n_bad++; $display("FAIL por_col_sel: got %b expected 00001", bus.col_sel); end
        n_vec++; if (bus.row_data !== 7'h00) begin n_bad++; $display("FAIL por_row: got %h expected 00", bus.row_data); end
        repeat (3) tick();
        reset_n = 1'b1;
        #1;
        n_vec++; if (bus.char_ready !== 1'b0) begin n_bad++; $display("FAIL ready_at_release: got %b expected 0", bus.char_ready); end
        tick();
        n_vec++; if (bus.char_ready !== 1'b1) begin n_bad++; $display("FAIL ready_one_cycle_after: got %b expected 1", bus.char_ready); end
    endtask

    task automatic test_single_load();
        bit ok;
        bit bad;
        logic [4:0] es;
        logic [6:0] er;
        handshake(4'h3, ok);
        n_vec++; if (!ok) begin n_bad++; $display("FAIL load_handshake: got no ready expected ready"); end
        for (int i = 0; i < 6; i++) begin
            n_vec++;
            if (bus.counter !== 4'(i) || bus.caracter_code !== 4'h3) begin
                n_bad++;
                $display("FAIL load_counter_seq: got cnt=%h code=%h expected cnt=%h code=3", bus.counter, bus.caracter_code, 4'(i));
            end
            tick();
        end
        wait_commit(7'h30, ok);
        n_vec++; if (!ok) begin n_bad++; $display("FAIL load_commit: got timeout expected row 30 on col 0"); end
        for (int c = 0; c < 5; c++) begin
            bad = 1'b0;
            for (int s = 0; s < COL_CYCLES; s++) begin
                if (!(c == 0 && s < DT_CYC)) begin
                    es = (s < DT_CYC) ? 5'b0 : 5'(1 << c);
                    er = (s < DT_CYC) ? 7'h00 : 7'h30 + 7'(c);
                    if (!bad && (bus.col_sel !== es || bus.row_data !== er)) begin
                        bad = 1'b1;
                        $display("FAIL col_hold_%0d: got sel=%b row=%h at cycle %0d expected sel=%b row=%h", c, bus.col_sel, bus.row_data, s, es, er);
                    end
                    tick();
                end
            end
            n_vec++; if (bad) n_bad++;
        end
        n_vec++; if (bus.counter !== 4'd0) begin n_bad++; $display("FAIL counter_after_commit: got %h expected 0", bus.counter); end
        n_vec++; if (bus.char_ready !== 1'b0) begin n_bad++; $display("FAIL ready_after_commit: got %b expected 0", bus.char_ready); end
    endtask

    task automatic test_back_pressure();
        bit ok;
        int cnt;
        handshake(4'h1, ok);
        n_vec++; if (!ok) begin n_bad++; $display("FAIL bp_handshake: got no ready expected ready"); end
        wait_commit(7'h10, ok);
        n_vec++; if (!ok) begin n_bad++; $display("FAIL bp_commit: got timeout expected row 10 on col 0"); end
        valid = 1'b1;
        code  = 4'h5;
        cnt   = 0;
        for (int i = 0; i < 300; i++) begin
            if (bus.char_ready === 1'b1) break;
            cnt++;
            tick();
        end
        n_vec++; if (cnt !== 100 - DT_CYC) begin n_bad++; $display("FAIL bp_ready_low_cycles: got %0d expected %0d", cnt, 100 - DT_CYC); end
        n_vec++; if (bus.caracter_code !== 4'h1) begin n_bad++; $display("FAIL bp_code_not_sampled: got %h expected 1", bus.caracter_code); end
        tick();
        valid = 1'b0;
        n_vec++;
        if (bus.caracter_code !== 4'h5 || bus.counter !== 4'd0 || bus.char_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL bp_first_ready_xfer: got code=%h cnt=%h rdy=%b expected code=5 cnt=0 rdy=0", bus.caracter_code, bus.counter, bus.char_ready);
        end
        wait_commit(7'h50, ok);
        n_vec++; if (!ok) begin n_bad++; $display("FAIL bp_second_commit: got timeout expected row 50 on col 0"); end
    endtask

    task automatic test_finish_timeout();
        bit ok;
        int at;
        no_finish = 1'b1;
        handshake(4'h6, ok);
        n_vec++; if (!ok) begin n_bad++; $display("FAIL to_handshake: got no ready expected ready"); end
        at = -1;
        for (int i = 0; i < 20; i++) begin
            if (bus.counter === 4'hF) begin
                at = i;
                break;
            end
            tick();
        end
        n_vec++; if (at !== 15) begin n_bad++; $display("FAIL to_reach_F: got cycle %0d expected 15", at); end
        tick();
        n_vec++; if (bus.counter !== 4'hF || bus.char_ready !== 1'b0) begin n_bad++; $display("FAIL to_load_exit: got cnt=%h rdy=%b expected cnt=f rdy=0", bus.counter, bus.char_ready); end
        wait_commit(7'h60, ok);
        n_vec++; if (!ok) begin n_bad++; $display("FAIL to_commit: got timeout expected row 60 on col 0"); end
        for (int c = 0; c < 5; c++) begin
            n_vec++;
            if (bus.col_sel !== 5'(1 << c) || bus.row_data !== 7'h60 + 7'(c)) begin
                n_bad++;
                $display("FAIL to_col_%0d: got sel=%b row=%h expected sel=%b row=%h", c, bus.col_sel, bus.row_data, 5'(1 << c), 7'h60 + 7'(c));
            end
            repeat (COL_CYCLES) tick();
        end
        n_vec++; if (bus.counter !== 4'd0) begin n_bad++; $display("FAIL to_counter_cleared: got %h expected 0", bus.counter); end
        no_finish = 1'b0;
    endtask

    task automatic test_reset();
        bit bad;
        @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        n_vec++;
        if (bus.char_ready !== 1'b0 || bus.caracter_code !== 4'd0 || bus.counter !== 4'd0 ||
            bus.col_sel !== 5'b00001 || bus.row_data !== 7'h00) begin
            n_bad++;
            $display("FAIL async_reset: got rdy=%b code=%h cnt=%h sel=%b row=%h expected 0 0 0 00001 00",
                     bus.char_ready, bus.caracter_code, bus.counter, bus.col_sel, bus.row_data);
        end
        bad = 1'b0;
        for (int i = 0; i < 15 * COL_CYCLES; i++) begin
            tick();
            if (!bad && (bus.col_sel !== 5'b00001 || bus.row_data !== 7'h00)) begin
                bad = 1'b1;
                $display("FAIL reset_hold: got sel=%b row=%h at cycle %0d expected 00001 00", bus.col_sel, bus.row_data, i);
            end
        end
        n_vec++; if (bad) n_bad++;
        reset_n = 1'b1;
        tick();
        n_vec++; if (bus.char_ready !== 1'b1) begin n_bad++; $display("FAIL ready_after_reset: got %b expected 1", bus.char_ready); end
    endtask

    task automatic test_reset_during_load();
        bit ok;
        bit bad_row;
        bit bad_rdy;
        int at;
        handshake(4'h7, ok);
        n_vec++; if (!ok) begin n_bad++; $display("FAIL rl_handshake: got no ready expected ready"); end
        at = -1;
        for (int i = 0; i < 10; i++) begin
            if (bus.counter === 4'd2) begin
                at = i;
                break;
            end
            tick();
        end
        n_vec++; if (at !== 2) begin n_bad++; $display("FAIL rl_reach_2: got cycle %0d expected 2", at); end
        reset_n = 1'b0;
        #1;
        n_vec++; if (bus.counter !== 4'd0 || bus.caracter_code !== 4'd0) begin n_bad++; $display("FAIL rl_async_clear: got cnt=%h code=%h expected 0 0", bus.counter, bus.caracter_code); end
        repeat (2) tick();
        reset_n = 1'b1;
        tick();
        n_vec++; if (bus.char_ready !== 1'b1) begin n_bad++; $display("FAIL rl_ready_back: got %b expected 1", bus.char_ready); end
        bad_row = 1'b0;
        bad_rdy = 1'b0;
        for (int i = 0; i < 15 * COL_CYCLES; i++) begin
            if (!bad_row && bus.row_data !== 7'h00) begin
                bad_row = 1'b1;
                $display("FAIL rl_display_blank: got row=%h at cycle %0d expected 00", bus.row_data, i);
            end
            if (!bad_rdy && bus.char_ready !== 1'b1) begin
                bad_rdy = 1'b1;
                $display("FAIL rl_ready_held: got %b at cycle %0d expected 1", bus.char_ready, i);
            end
            tick();
        end
        n_vec++; if (bad_row) n_bad++;
        n_vec++; if (bad_rdy) n_bad++;
    endtask

    task automatic test_deadtime();
        bit ok;
        bit bad;
        logic [4:0] es;
        logic [6:0] er;
        handshake(4'h2, ok);
        n_vec++; if (!ok) begin n_bad++; $display("FAIL dt_handshake: got no ready expected ready"); end
        wait_commit(7'h20, ok);
        n_vec++; if (!ok) begin n_bad++; $display("FAIL dt_commit: got timeout expected row 20 on col 0"); end
`ifdef CHAR_SCAN_DEADTIME_EN
        repeat (COL_CYCLES - DEADTIME) tick();
        for (int c = 1; c < 5; c++) begin
            bad = 1'b0;
            for (int s = 0; s < COL_CYCLES; s++) begin
                es = (s < DEADTIME) ? 5'b0 : 5'(1 << c);
                er = (s < DEADTIME) ? 7'h00 : 7'h20 + 7'(c);
                if (!bad && (bus.col_sel !== es || bus.row_data !== er)) begin
                    bad = 1'b1;
                    $display("FAIL dt_slot_%0d: got sel=%b row=%h at cycle %0d expected sel=%b row=%h", c, bus.col_sel, bus.row_data, s, es, er);
                end
                tick();
            end
            n_vec++; if (bad) n_bad++;
        end
`else
        bad = 1'b0;
        es  = 5'b00001;
        er  = 7'h20;
        for (int s = 0; s < DEADTIME; s++) begin
            if (!bad && (bus.col_sel !== es || bus.row_data !== er)) begin
                bad = 1'b1;
                $display("FAIL no_blank: got sel=%b row=%h at cycle %0d expected sel=%b row=%h", bus.col_sel, bus.row_data, s, es, er);
            end
            tick();
        end
        n_vec++; if (bad) n_bad++;
`endif
    endtask

    initial begin
        test_reset_init();
        test_single_load();
        test_back_pressure();
        test_finish_timeout();
        test_reset();
        test_reset_during_load();
        test_deadtime();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
